// File: rtl/peripheral_bus_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-peripheral-core bridge:
// FSM states, register map, CONFIG bit positions and the byte-lane merge.
package peripheral_bridge_pkg;

  localparam int WB_ADR_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REG_ACK = 3'd1,
    ST_MEM_RD  = 3'd2,
    ST_MEM_ACK = 3'd3,
    ST_RMW_WR  = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  localparam logic [WB_ADR_W-1:0] ADR_COUNT    = 11'h000;
  localparam logic [WB_ADR_W-1:0] ADR_CONFIG   = 11'h004;
  localparam logic [WB_ADR_W-1:0] ADR_STATUS   = 11'h008;
  localparam logic [WB_ADR_W-1:0] ADR_MEM_BASE = 11'h400;

  localparam int CFG_EN_BIT  = 0;
  localparam int CFG_DIR_BIT = 1;
  localparam int CFG_IRE_BIT = 2;

  // Selected lanes come from new_data, the rest keep old_data.
  function automatic logic [31:0] byte_merge(input logic [3:0]  sel,
                                             input logic [31:0] new_data,
                                             input logic [31:0] old_data);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = sel[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/peripheral_bus_bridge_if.sv
// Wishbone B4 classic bus bundle between a bus master and the bridge.
interface peripheral_bus_bridge_if
  import peripheral_bridge_pkg::*;
#(
  parameter int ADDR_W = WB_ADR_W
);
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;
  logic              wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/peripheral_bus_bridge.sv
// Wishbone classic slave that turns bus cycles into the peripheral core's
// register strobes and memory port; partial memory writes use read-modify-write.
module peripheral_bus_bridge
  import peripheral_bridge_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = WB_ADR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  peripheral_bus_bridge_if.slave       wb,
  output logic                         count_we,
  output logic [31:0]                  count_in,
  output logic                         config_we,
  output logic                         en_in,
  output logic                         dir_in,
  output logic                         ire_in,
  input  logic [31:0]                  count_out,
  input  logic                         en_out,
  input  logic                         dir_out,
  input  logic                         ire_out,
  input  logic                         lt_1k_out,
  output logic                         mem_write_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_address,
  output logic [31:0]                  mem_data_in,
  input  logic [31:0]                  mem_data_out
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                count_we_q, count_we_d;
  logic [31:0]         count_in_q, count_in_d;
  logic                config_we_q, config_we_d;
  logic [2:0]          cfg_q, cfg_d;
  logic                mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdat_q, wdat_d;
  logic                we_q, we_d;

  logic                req_s;
  logic                is_mem_s;
  logic [ADDR_W-3:0]   word_s;
  logic                unused_adr_s;

  assign req_s        = wb.wb_cyc_i & wb.wb_stb_i;
  assign is_mem_s     = wb.wb_adr_i[ADDR_W-1];
  assign word_s       = wb.wb_adr_i[ADDR_W-1:2];
  assign unused_adr_s = ^wb.wb_adr_i[1:0];

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rd_data_d   = 32'd0;
    count_we_d  = 1'b0;
    count_in_d  = 32'd0;
    config_we_d = 1'b0;
    cfg_d       = 3'd0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = 32'd0;
    sel_d       = sel_q;
    wdat_d      = wdat_q;
    we_d        = we_q;

    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          sel_d  = wb.wb_sel_i;
          wdat_d = wb.wb_dat_i;
          we_d   = wb.wb_we_i;
          if (is_mem_s) begin
            mem_addr_d = wb.wb_adr_i[MEM_AW+1:2];
            if (!wb.wb_we_i) begin
              state_d = ST_MEM_RD;
            end else if (wb.wb_sel_i == 4'hF) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = wb.wb_dat_i;
              ack_d       = 1'b1;
              state_d     = ST_MEM_ACK;
            end else if (wb.wb_sel_i == 4'h0) begin
              ack_d   = 1'b1;
              state_d = ST_MEM_ACK;
            end else begin
              state_d = ST_MEM_RD;
            end
          end else if (word_s == ADR_COUNT[ADDR_W-1:2]) begin
            ack_d   = 1'b1;
            state_d = ST_REG_ACK;
            if (wb.wb_we_i) begin
              count_we_d = 1'b1;
              count_in_d = byte_merge(wb.wb_sel_i, wb.wb_dat_i, count_out);
            end else begin
              rd_data_d = count_out;
            end
          end else if (word_s == ADR_CONFIG[ADDR_W-1:2]) begin
            ack_d   = 1'b1;
            state_d = ST_REG_ACK;
            if (wb.wb_we_i) begin
              // CONFIG bits live in byte lane 0 only.
              if (wb.wb_sel_i[0]) begin
                config_we_d        = 1'b1;
                cfg_d[CFG_EN_BIT]  = wb.wb_dat_i[CFG_EN_BIT];
                cfg_d[CFG_DIR_BIT] = wb.wb_dat_i[CFG_DIR_BIT];
                cfg_d[CFG_IRE_BIT] = wb.wb_dat_i[CFG_IRE_BIT];
              end else begin
                config_we_d = 1'b0;
              end
            end else begin
              rd_data_d = {29'd0, ire_out, dir_out, en_out};
            end
          end else if (word_s == ADR_STATUS[ADDR_W-1:2]) begin
            ack_d   = 1'b1;
            state_d = ST_REG_ACK;
            if (!wb.wb_we_i) begin
              rd_data_d = {31'd0, lt_1k_out};
            end else begin
              rd_data_d = 32'd0;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MEM_RD: begin
        if (!wb.wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (we_q) begin
          mem_we_d = 1'b1;
          ack_d    = 1'b1;
          state_d  = ST_RMW_WR;
        end else begin
          ack_d   = 1'b1;
          state_d = ST_MEM_ACK;
        end
      end

      ST_REG_ACK, ST_MEM_ACK, ST_RMW_WR, ST_ERR: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= 32'd0;
      count_we_q  <= 1'b0;
      count_in_q  <= 32'd0;
      config_we_q <= 1'b0;
      cfg_q       <= 3'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      sel_q       <= 4'd0;
      wdat_q      <= 32'd0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      count_we_q  <= count_we_d;
      count_in_q  <= count_in_d;
      config_we_q <= config_we_d;
      cfg_q       <= cfg_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sel_q       <= sel_d;
      wdat_q      <= wdat_d;
      we_q        <= we_d;
    end
  end

  // Memory read data and the RMW merge are only valid in the cycle they are used.
  assign wb.wb_dat_o  = (state_q == ST_MEM_ACK && !we_q) ? mem_data_out : rd_data_q;
  assign mem_data_in  = (state_q == ST_RMW_WR) ? byte_merge(sel_q, wdat_q, mem_data_out)
                                                : mem_wdata_q;
  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_err_o  = err_q;
  assign count_we     = count_we_q;
  assign count_in     = count_in_q;
  assign config_we    = config_we_q;
  assign en_in        = cfg_q[CFG_EN_BIT];
  assign dir_in       = cfg_q[CFG_DIR_BIT];
  assign ire_in       = cfg_q[CFG_IRE_BIT];
  assign mem_write_en = mem_we_q;
  assign mem_address  = mem_addr_q;

endmodule
